fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a 2-entry queue. Presents one {pc, instruction} pair at a time to decode over valid/ready. Accepts redirects from execute (branches, JAL/JALR) and flushes all wrong-path work.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/ack, decode valid/ready,
// execute redirect and the misalignment fault flag.
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_fault;

    // Fetch unit side
    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_ack, i_imem_data,
        output o_valid, o_inst, o_pc,
        input  i_ready,
        input  i_redirect, i_redirect_pc,
        output o_fault
    );

    // Memory / decode / execute side
    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_ack, i_imem_data,
        input  o_valid, o_inst, o_pc,
        output i_ready,
        output i_redirect, i_redirect_pc,
        input  o_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over req/ack,
// buffers up to two {pc, inst} entries for decode and handles redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises o_fault instead of silently aligning the target).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_unit_if.master  bus
);
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {RUN, WAIT_SPACE, DISCARD, HALT} state_e;
`else
    typedef enum logic [1:0] {RUN, WAIT_SPACE, DISCARD} state_e;
`endif

    state_e          state_q, state_d;
    entry_t          q0_q, q0_d, q1_q, q1_d;
    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            ack, pop, pending, push;
    logic [XLEN-1:0] redir_tgt;
    entry_t          new_entry;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault_q, fault_d;
    logic            halt_pend_q, halt_pend_d;
    logic            misaligned;
`endif

    assign ack       = req_q && bus.i_imem_ack;
    assign pop       = valid_q && bus.i_ready;
    assign pending   = req_q && !bus.i_imem_ack;
    assign new_entry = '{pc: addr_q, inst: bus.i_imem_data};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = bus.i_redirect_pc[1:0] != 2'b00;
    assign redir_tgt  = bus.i_redirect_pc;
`else
    assign redir_tgt  = bus.i_redirect_pc & ~XLEN'(3);
`endif

    // Next-state, queue and registered-output computation
    always_comb begin
        state_d = state_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        count_d = count_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        push    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_pend_d = halt_pend_q;
`endif
        if (bus.i_redirect) begin
            count_d = 2'd0;
            if (pending) begin
                state_d = DISCARD;
                tgt_d   = redir_tgt;
            end else begin
                state_d = RUN;
                addr_d  = redir_tgt;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_pend_d = 1'b0;
            if (misaligned) begin
                q0_d.pc = bus.i_redirect_pc;
                if (pending) begin
                    halt_pend_d = 1'b1;
                end else begin
                    state_d = HALT;
                end
            end
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (ack) begin
                        push   = 1'b1;
                        addr_d = addr_q + XLEN'(4);
                    end
                end
                WAIT_SPACE: begin
                    if (pop) state_d = RUN;
                end
                DISCARD: begin
                    if (ack) begin
                        addr_d  = tgt_q;
                        state_d = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (halt_pend_q) begin
                            state_d     = HALT;
                            halt_pend_d = 1'b0;
                        end
`endif
                    end
                end
                default: ;
            endcase
            if (pop) q0_d = q1_q;
            if (push) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                    q0_d = new_entry;
                end else begin
                    q1_d = new_entry;
                end
            end
            count_d = count_q + 2'(push) - 2'(pop);
            if (state_q == RUN && count_d == 2'd2) state_d = WAIT_SPACE;
        end
        req_d   = (state_d == RUN) || (state_d == DISCARD);
        valid_d = count_d != 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = state_d == HALT;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
            q0_q    <= '{pc: RESET_PC, inst: XLEN'(0)};
            q1_q    <= '{pc: RESET_PC, inst: XLEN'(0)};
            count_q <= 2'd0;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    assign bus.o_imem_req  = req_q;
    assign bus.o_imem_addr = addr_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_inst      = q0_q.inst;
    assign bus.o_pc        = q0_q.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.o_fault     = fault_q;
`else
    assign bus.o_fault     = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory model, an instruction-stream
// scoreboard checked every cycle, and directed scenarios with literal values.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Memory: acks after 'waits' stall cycles, returns address xor mask
    int unsigned waits = 0;
    int unsigned wcnt  = 0;
    logic [31:0] mask  = 32'h0;
    always @(posedge clk) begin
        if (rst) wcnt <= 0;
        else if (bus.o_imem_req && bus.i_imem_ack) wcnt <= 0;
        else if (bus.o_imem_req) wcnt <= wcnt + 1;
    end
    assign bus.i_imem_ack  = bus.o_imem_req && (wcnt >= waits);
    assign bus.i_imem_data = bus.o_imem_addr ^ mask;

    // Scoreboard: program-order stream, occupancy and request-order model
    int          m_occ;
    logic [31:0] m_exp_pc, m_fetch, m_drain_addr, m_pend_addr, m_halt_pc, m_tgt;
    logic        m_drain, m_pend, m_halt, m_halt_pend;
    logic        m_pop, m_ack, m_push;
    always @(negedge clk) begin
        if (rst) begin
            m_occ = 0; m_exp_pc = 32'h0; m_fetch = 32'h0;
            m_drain = 1'b0; m_pend = 1'b0; m_halt = 1'b0; m_halt_pend = 1'b0;
        end else begin
            m_pop  = bus.o_valid && bus.i_ready;
            m_ack  = bus.o_imem_req && bus.i_imem_ack;
            m_push = 1'b0;
            chk("valid_vs_occ", 32'(bus.o_valid), 32'(m_occ != 0));
            chk("fault_vs_model", 32'(bus.o_fault), 32'(m_halt));
            if (m_occ == 2) chk("req_when_full", 32'(bus.o_imem_req), 32'(0));
            if (bus.o_imem_req) chk("addr_aligned", 32'(bus.o_imem_addr[1:0]), 32'(0));
            if (m_pend) begin
                chk("req_held", 32'(bus.o_imem_req), 32'(1));
                chk("addr_held", bus.o_imem_addr, m_pend_addr);
            end
            if (m_halt) begin
                chk("halt_req", 32'(bus.o_imem_req), 32'(0));
                chk("halt_pc", bus.o_pc, m_halt_pc);
            end
            m_pend      = bus.o_imem_req && !bus.i_imem_ack;
            m_pend_addr = bus.o_imem_addr;
            if (bus.i_redirect) begin
                m_occ = 0;
                if (bus.o_imem_req && !bus.i_imem_ack) begin
                    if (!m_drain) m_drain_addr = bus.o_imem_addr;
                    m_drain = 1'b1;
                end else begin
                    m_drain = 1'b0;
                end
                m_halt = 1'b0; m_halt_pend = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (bus.i_redirect_pc[1:0] != 2'b00) begin
                    m_halt_pc = bus.i_redirect_pc;
                    if (m_drain) m_halt_pend = 1'b1; else m_halt = 1'b1;
                end
`endif
                m_tgt    = bus.i_redirect_pc & 32'hFFFF_FFFC;
                m_fetch  = m_tgt;
                m_exp_pc = m_tgt;
            end else begin
                if (m_ack) begin
                    if (m_drain) begin
                        chk("discard_addr", bus.o_imem_addr, m_drain_addr);
                        m_drain = 1'b0;
                        if (m_halt_pend) begin m_halt = 1'b1; m_halt_pend = 1'b0; end
                    end else begin
                        chk("fetch_addr", bus.o_imem_addr, m_fetch);
                        m_fetch = m_fetch + 32'd4;
                        m_push  = 1'b1;
                    end
                end
                if (m_pop) begin
                    chk("pop_pc", bus.o_pc, m_exp_pc);
                    chk("pop_inst", bus.o_inst, bus.o_pc ^ mask);
                    m_exp_pc = m_exp_pc + 32'd4;
                end
                m_occ = m_occ + int'(m_push) - int'(m_pop);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] mk, input int unsigned ws, input logic rdy);
        rst = 1'b1;
        bus.i_redirect = 1'b0;
        bus.i_ready    = rdy;
        step();
        step();
        mask  = mk;
        waits = ws;
        rst   = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = pc;
        step();
        bus.i_redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.i_ready = 1'b1;
        bus.i_redirect = 1'b0;
        bus.i_redirect_pc = 32'h0;

        // Reset values, then back-to-back zero-wait fetch with data = addr
        do_reset(32'h0, 0, 1'b1);
        chk("rst_req", 32'(bus.o_imem_req), 32'(0));
        chk("rst_addr", bus.o_imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'(0));
        chk("rst_inst", bus.o_inst, 32'h0);
        chk("rst_pc", bus.o_pc, 32'h0);
        chk("rst_fault", 32'(bus.o_fault), 32'(0));
        step();
        chk("p1_req0", 32'(bus.o_imem_req), 32'(1));
        chk("p1_addr0", bus.o_imem_addr, 32'h0);
        step();
        chk("p1_addr4", bus.o_imem_addr, 32'h4);
        chk("p1_valid", 32'(bus.o_valid), 32'(1));
        chk("p1_pc0", bus.o_pc, 32'h0);
        step();
        chk("p1_addr8", bus.o_imem_addr, 32'h8);
        chk("p1_pc4", bus.o_pc, 32'h4);
        chk("p1_inst4", bus.o_inst, 32'h4);
        step();
        chk("p1_pc8", bus.o_pc, 32'h8);
        chk("p1_inst8", bus.o_inst, 32'h8);

        // Decode stalled: queue fills to two, request drops, order preserved
        do_reset(32'h0013_0000, 0, 1'b0);
        repeat (5) step();
        chk("p2_req_low", 32'(bus.o_imem_req), 32'(0));
        chk("p2_valid", 32'(bus.o_valid), 32'(1));
        chk("p2_pc0", bus.o_pc, 32'h0);
        chk("p2_inst0", bus.o_inst, 32'h0013_0000);
        bus.i_ready = 1'b1;
        step();
        chk("p2_pc4", bus.o_pc, 32'h4);
        chk("p2_req8", 32'(bus.o_imem_req), 32'(1));
        chk("p2_addr8", bus.o_imem_addr, 32'h8);
        step();
        chk("p2_pc8", bus.o_pc, 32'h8);
        chk("p2_inst8", bus.o_inst, 32'h0013_0008);

        // Three wait states; redirect while the fetch of 0x8 is pending
        do_reset(32'h0013_0000, 3, 1'b1);
        n = 0;
        while (!(bus.o_imem_req && bus.o_imem_addr == 32'h8 && !bus.i_imem_ack) && n < 40) begin
            step();
            n++;
        end
        chk("p3_found_pending", 32'(n < 40), 32'(1));
        redirect(32'h100);
        chk("p3_valid_flushed", 32'(bus.o_valid), 32'(0));
        for (int i = 0; i < 3; i++) begin
            chk("p3_addr_held", bus.o_imem_addr, 32'h8);
            step();
        end
        chk("p3_req_tgt", 32'(bus.o_imem_req), 32'(1));
        chk("p3_addr_tgt", bus.o_imem_addr, 32'h100);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            step();
            n++;
        end
        chk("p3_first_pc", bus.o_pc, 32'h100);

        // Redirect in the same cycle as an ack and a pop
        do_reset(32'h0013_0000, 0, 1'b1);
        repeat (4) step();
        chk("p4_ack_and_pop", 32'({bus.o_imem_req, bus.i_imem_ack, bus.o_valid}), 32'h7);
        redirect(32'h40);
        chk("p4_valid0", 32'(bus.o_valid), 32'(0));
        chk("p4_req", 32'(bus.o_imem_req), 32'(1));
        chk("p4_addr40", bus.o_imem_addr, 32'h40);
        step();
        chk("p4_pc40", bus.o_pc, 32'h40);
        chk("p4_inst40", bus.o_inst, 32'h0013_0040);

        // Fetch PC wraps past the top of the address space
        redirect(32'hFFFF_FFFC);
        chk("p5_addr_top", bus.o_imem_addr, 32'hFFFF_FFFC);
        step();
        chk("p5_addr_wrap", bus.o_imem_addr, 32'h0);
        chk("p5_pc_top", bus.o_pc, 32'hFFFF_FFFC);
        step();
        chk("p5_pc_wrap", bus.o_pc, 32'h0);

        // Misaligned redirect
        redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            chk("p6_fault", 32'(bus.o_fault), 32'(1));
            chk("p6_req_off", 32'(bus.o_imem_req), 32'(0));
            chk("p6_valid_off", 32'(bus.o_valid), 32'(0));
            chk("p6_fault_pc", bus.o_pc, 32'h102);
            step();
        end
        redirect(32'h200);
        chk("p6_fault_clr", 32'(bus.o_fault), 32'(0));
        chk("p6_req_on", 32'(bus.o_imem_req), 32'(1));
        chk("p6_addr200", bus.o_imem_addr, 32'h200);
        step();
        chk("p6_pc200", bus.o_pc, 32'h200);
`else
        chk("p6_fault0", 32'(bus.o_fault), 32'(0));
        chk("p6_req", 32'(bus.o_imem_req), 32'(1));
        chk("p6_addr100", bus.o_imem_addr, 32'h100);
        step();
        chk("p6_pc100", bus.o_pc, 32'h100);
`endif

        // Reset while draining a wrong-path request
        do_reset(32'h0013_0000, 2, 1'b1);
        step();
        redirect(32'h80);
        rst = 1'b1;
        step();
        chk("p7_rst_req", 32'(bus.o_imem_req), 32'(0));
        chk("p7_rst_valid", 32'(bus.o_valid), 32'(0));
        chk("p7_rst_addr", bus.o_imem_addr, 32'h0);
        rst = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 20) begin
            step();
            n++;
        end
        chk("p7_restart_pc", bus.o_pc, 32'h0);
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
